// File: rtl/jk_bank_seq.sv
// Command sequencer for a bank of W JK flip-flops: drives per-bit j/k for a
// latched operation over a programmed number of bank edges, using live q feedback.
`timescale 1ns/1ps

module jk_bank_seq #(
  parameter int W    = 4,
  parameter int LENW = 8
) (
  input  logic            clk,
  input  logic            cl,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [W-1:0]    cmd_data,
  input  logic [LENW-1:0] cmd_len,
  input  logic [W-1:0]    q,
  output logic [W-1:0]    j,
  output logic [W-1:0]    k,
  output logic            busy,
  output logic            done,
  output logic            wrap
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP        = 3'b000,
    OP_LOAD       = 3'b001,
    OP_CLEAR      = 3'b010,
    OP_SET        = 3'b011,
    OP_COUNT_UP   = 3'b100,
    OP_COUNT_DOWN = 3'b101,
    OP_SHIFT_LEFT = 3'b110,
    OP_INVERT     = 3'b111
  } op_t;

  localparam logic [LENW:0] ONE = {{LENW{1'b0}}, 1'b1};

  state_t        state, state_next;
  op_t           op_q;
  logic [W-1:0]  data_q;
  logic [LENW:0] remaining;
  logic          accept;
  logic          last_edge;

  always_ff @(posedge clk or negedge cl) begin
    if (!cl) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    last_edge  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (remaining == ONE) begin
          last_edge  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Command fields are captured only at the accept edge; remaining counts bank edges left.
  always_ff @(posedge clk or negedge cl) begin
    if (!cl) begin
      op_q      <= OP_NOP;
      data_q    <= '0;
      remaining <= '0;
      done      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      done <= last_edge;
      if (accept) begin
        op_q      <= op_t'(cmd_op);
        data_q    <= cmd_data;
        remaining <= {1'b0, cmd_len} + ONE;
        wrap      <= 1'b0;
      end else if (state == RUN) begin
        remaining <= remaining - ONE;
        if ((op_q == OP_COUNT_UP && (&q)) || (op_q == OP_COUNT_DOWN && !(|q))) begin
          wrap <= 1'b1;
        end
      end
    end
  end

  // Toggle enables for counting are the running AND of lower bits (true or inverted).
  always_comb begin
    logic acc_up;
    logic acc_dn;
    j      = '0;
    k      = '0;
    acc_up = 1'b1;
    acc_dn = 1'b1;
    if (state == RUN) begin
      case (op_q)
        OP_NOP: begin
          j = '0;
          k = '0;
        end
        OP_LOAD: begin
          j = data_q;
          k = ~data_q;
        end
        OP_CLEAR: begin
          j = '0;
          k = '1;
        end
        OP_SET: begin
          j = '1;
          k = '0;
        end
        OP_COUNT_UP: begin
          for (int i = 0; i < W; i++) begin
            j[i]   = acc_up;
            k[i]   = acc_up;
            acc_up = acc_up & q[i];
          end
        end
        OP_COUNT_DOWN: begin
          for (int i = 0; i < W; i++) begin
            j[i]   = acc_dn;
            k[i]   = acc_dn;
            acc_dn = acc_dn & ~q[i];
          end
        end
        OP_SHIFT_LEFT: begin
          j = {q[W-2:0], data_q[0]};
          k = ~{q[W-2:0], data_q[0]};
        end
        OP_INVERT: begin
          j = '1;
          k = '1;
        end
        default: begin
          j = '0;
          k = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_seq.sv
// Directed bench for jk_bank_seq; a behavioural JK bank closes the q feedback loop.
`timescale 1ns/1ps

module tb_jk_bank_seq;

  localparam int W    = 4;
  localparam int LENW = 8;

  localparam logic [2:0] NOP        = 3'b000;
  localparam logic [2:0] LOAD       = 3'b001;
  localparam logic [2:0] CLEAR      = 3'b010;
  localparam logic [2:0] SET        = 3'b011;
  localparam logic [2:0] COUNT_UP   = 3'b100;
  localparam logic [2:0] COUNT_DOWN = 3'b101;
  localparam logic [2:0] SHIFT_LEFT = 3'b110;
  localparam logic [2:0] INVERT     = 3'b111;

  logic            clk = 1'b0;
  logic            cl;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic [W-1:0]    cmd_data;
  logic [LENW-1:0] cmd_len;
  logic [W-1:0]    q;
  logic [W-1:0]    j;
  logic [W-1:0]    k;
  logic            busy;
  logic            done;
  logic            wrap;

  int checkCount = 0;
  int passCount  = 0;

  jk_bank_seq #(.W(W), .LENW(LENW)) dut (
    .clk       (clk),
    .cl        (cl),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .q         (q),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  // Reference JK bank: q+ = j&~q | ~k&q, cleared asynchronously by cl.
  always @(posedge clk or negedge cl) begin
    if (!cl) begin
      q <= '0;
    end else begin
      for (int i = 0; i < W; i++) begin
        q[i] <= (j[i] & ~q[i]) | (~k[i] & q[i]);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Issues one command from IDLE and waits (bounded) for its done pulse.
  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] data,
                               input logic [LENW-1:0] len);
    int cycles;
    bit got;
    @(negedge clk);
    cmd_op    = op;
    cmd_data  = data;
    cmd_len   = len;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    checkOutput("accept_busy", 32'(busy), 32'd1);
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < int'(len) + 10) begin
      @(posedge clk);
      #1;
      cycles++;
      if (done) got = 1'b1;
    end
    checkOutput("done_latency", 32'(cycles), 32'(int'(len) + 1));
    checkOutput("done_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    cl        = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = NOP;
    cmd_data  = '0;
    cmd_len   = '0;
    #12;
    checkOutput("rst_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_wrap", 32'(wrap), 32'd0);
    checkOutput("rst_j", 32'(j), 32'd0);
    checkOutput("rst_k", 32'(k), 32'd0);
    @(negedge clk);
    cl = 1'b1;

    applyStimulus(LOAD, 4'b1010, 8'd0);
    checkOutput("load_q", 32'(q), 32'b1010);
    checkOutput("load_wrap", 32'(wrap), 32'd0);

    applyStimulus(CLEAR, 4'b0000, 8'd0);
    checkOutput("clear_q", 32'(q), 32'd0);
    applyStimulus(COUNT_UP, 4'b0000, 8'd17);
    checkOutput("up_q", 32'(q), 32'b0010);
    checkOutput("up_wrap", 32'(wrap), 32'd1);

    applyStimulus(LOAD, 4'b0011, 8'd0);
    checkOutput("load2_wrap_cleared", 32'(wrap), 32'd0);
    applyStimulus(COUNT_DOWN, 4'b0000, 8'd2);
    checkOutput("down_q", 32'(q), 32'b0000);
    checkOutput("down_wrap", 32'(wrap), 32'd0);
    applyStimulus(COUNT_DOWN, 4'b0000, 8'd0);
    checkOutput("down_wrap_q", 32'(q), 32'b1111);
    checkOutput("down_wrap_flag", 32'(wrap), 32'd1);

    applyStimulus(LOAD, 4'b0000, 8'd0);
    applyStimulus(SHIFT_LEFT, 4'b0001, 8'd2);
    checkOutput("shift_q", 32'(q), 32'b0111);
    applyStimulus(INVERT, 4'b0000, 8'd0);
    checkOutput("invert_q", 32'(q), 32'b1000);

    // Back-to-back with cmd_valid held high; fields change after the accept edge.
    @(negedge clk);
    cmd_op    = NOP;
    cmd_data  = 4'b0000;
    cmd_len   = 8'd3;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_op   = SET;
    cmd_len  = 8'd0;
    checkOutput("b2b_busy", 32'(busy), 32'd1);
    checkOutput("nop_j", 32'(j), 32'd0);
    checkOutput("nop_k", 32'(k), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("b2b_done1", 32'(done), 32'd1);
    checkOutput("b2b_nop_q", 32'(q), 32'b1000);
    checkOutput("b2b_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    checkOutput("b2b_accept2", 32'(busy), 32'd1);
    checkOutput("b2b_done_drop", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("b2b_done2", 32'(done), 32'd1);
    checkOutput("b2b_set_q", 32'(q), 32'b1111);

    // Long count aborted by reset mid-run.
    @(negedge clk);
    cmd_op    = COUNT_UP;
    cmd_data  = 4'b0000;
    cmd_len   = 8'd200;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    checkOutput("abort_pre_q", 32'(q), 32'd13);
    checkOutput("abort_pre_wrap", 32'(wrap), 32'd1);
    checkOutput("abort_pre_busy", 32'(busy), 32'd1);
    @(negedge clk);
    cl = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_ready", 32'(cmd_ready), 32'd1);
    checkOutput("abort_wrap", 32'(wrap), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_j", 32'(j), 32'd0);
    checkOutput("abort_q", 32'(q), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    cl = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_no_done", 32'(done), 32'd0);
    applyStimulus(LOAD, 4'b0101, 8'd1);
    checkOutput("post_abort_q", 32'(q), 32'b0101);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/jk_bank_seq.md
# jk_bank_seq

Sequencer for a bank of W gate-level JK flip-flops (one jkffgl per bit, sharing clk and cl). It accepts commands over a valid/ready handshake and drives the per-bit j/k vectors so that the bank performs one of several operations for a programmed number of clock edges:

- load
- clear
- set
- count up or down
- shift
- invert

Bank outputs q are fed back so the counting and shift modes are computed from the live register state.

## Interface
- W, default 4: number of JK flip-flops in the bank (≥ 2).
- LENW, default 8: width of the repeat-count field.

- clk  in  1  single clock; also clocks the JK bank.
- cl  in  1  reset, asynchronous, active-low. Also wired to the bank's cl.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high when the sequencer can accept a command (state IDLE).
- cmd_op  in  3  operation code (see Operation).
- cmd_data  in  W  load value; bit 0 is also the serial-in for SHIFT.
- cmd_len  in  LENW  number of bank edges to apply, minus 1 (range 1..2^LENW).
- q  in  W  bank outputs, fed back.
- j  out  W  J inputs to the bank.
- k  out  W  K inputs to the bank.
- busy  out  1  high in state RUN.
- done  out  1  one-cycle pulse after the last edge of a command.
- wrap  out  1  sticky; set if a COUNT command wrapped; valid with done.

## Operation
- States: IDLE, RUN. Reset → IDLE.
- In IDLE:
  - cmd_ready = 1; j = k = 0 (bank holds).
  - Accept on the posedge where cmd_valid && cmd_ready.
  - On accept, latch op, data and remaining = cmd_len + 1 (LENW+1 bits), clear wrap, go to RUN.
- In RUN:
  - j/k are combinational from the latched op, latched data and live q.
  - Each posedge decrements remaining.
  - On the posedge where remaining == 1: go to IDLE and register done = 1 for one cycle.
- Opcodes:
  - 000 NOP: j = k = 0, bank holds; used as a timed wait.
  - 001 LOAD: j = data, k = ~data.
  - 010 CLEAR: j = 0, k = all ones.
  - 011 SET: j = all ones, k = 0.
  - 100 COUNT_UP: j[i] = k[i] = AND of q[i-1:0]; j[0] = k[0] = 1.
  - 101 COUNT_DOWN: j[i] = k[i] = AND of ~q[i-1:0]; j[0] = k[0] = 1.
  - 110 SHIFT_LEFT: j[0] = data[0], k[0] = ~data[0]; for i ≥ 1, j[i] = q[i-1], k[i] = ~q[i-1].
  - 111 INVERT: j = k = all ones (toggle every bit).
- wrap:
  - Set at any RUN posedge where op = COUNT_UP and q is all ones, or op = COUNT_DOWN and q is all zeros.
  - Holds until the next accept or reset.
- cmd_valid while busy is ignored; no queueing.
- cmd inputs are sampled only at the accept edge; later changes have no effect.

## Timing
- Reset (cl low, asynchronous) forces:
  - state = IDLE, remaining = 0, latched op = NOP, latched data = 0.
  - done = 0, wrap = 0, busy = 0, cmd_ready = 1, j = k = 0.
- Reset mid-RUN aborts the command immediately with no done pulse. The bank is cleared by the same cl.
- First cycle after cl deasserts: cmd_ready = 1; a command may be accepted at the first posedge.
- Latency for a command accepted at edge E0:
  - The bank applies the op at edges E1..E(len+1).
  - busy is high from E0 until E(len+1).
  - done is high for the cycle following E(len+1); wrap is valid in that same cycle.
- Back-to-back: the next accept is possible at E(len+2). Exactly one hold edge separates commands.
- j/k change only after clk edges or q changes; there is no combinational path from cmd_* to j/k.

## Test plan
- Reset, then LOAD data=4'b1010 len=0 → q = 1010 after E1; done high in cycle after E1; wrap = 0.
- CLEAR len=0, then COUNT_UP len=17 → q steps 0,1,…,15,0,1; final q = 4'b0010; wrap = 1 with done.
- LOAD 4'b0011, then COUNT_DOWN len=2 → q = 0010, 0001, 0000; wrap = 0. Then COUNT_DOWN len=0 → q = 1111, wrap = 1.
- LOAD 0, SHIFT_LEFT data[0]=1 len=2 → q = 0001, 0011, 0111. Then INVERT len=0 → q = 1000.
- cmd_valid held high continuously with NOP len=3 then SET len=0 → second accept exactly one edge after the first command's last edge; q = 1111; done pulses twice.
- COUNT_UP len=200 with cl pulsed low mid-run → outputs return to reset values immediately, no done; the next command is accepted normally.
